// File: rtl/ctrl_decode_pipe.sv
// Registered MIPS control decoder at the ID/EX boundary: one instruction per cycle,
// with load-use stalling, flush bubbles, illegal-op flagging and a syscall drain/handshake FSM.
module ctrl_decode_pipe #(
    parameter int ALUOP_W      = 3,
    parameter int REG_W        = 5,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          instr,
    input  logic                 instr_valid,
    input  logic                 idex_memread,
    input  logic [REG_W-1:0]     idex_rt,
    input  logic                 branch_taken,
    input  logic                 syscall_ack,
    output logic [ALUOP_W+1:0]   ex_ctrl,
    output logic [1:0]           mem_ctrl,
    output logic [1:0]           wb_ctrl,
    output logic                 jump,
    output logic                 branch,
    output logic                 jr_ctrl,
    output logic                 jal_ctrl,
    output logic                 syscall_ctrl,
    output logic                 ctrl_valid,
    output logic                 stall,
    output logic                 illegal,
    output logic                 syscall_req
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t             state_reg;
    logic [3:0]         drain_cnt_reg;
    logic [ALUOP_W+1:0] ex_ctrl_reg;
    logic [1:0]         mem_ctrl_reg;
    logic [1:0]         wb_ctrl_reg;
    logic               jump_reg;
    logic               branch_reg;
    logic               jr_reg;
    logic               jal_reg;
    logic               syscall_reg;
    logic               ctrl_valid_reg;
    logic               illegal_reg;
    logic               syscall_req_reg;

    logic [5:0]         op;
    logic [5:0]         funct;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic               uses_rt;
    logic               load_use;
    logic               accept;
    logic               unused_instr_bits;

    assign op    = instr[31:26];
    assign funct = instr[5:0];
    assign rs    = REG_W'(instr[25:21]);
    assign rt    = REG_W'(instr[20:16]);
    assign unused_instr_bits = ^instr[15:6];

    // rt is only a source operand for R-type, branches and stores
    assign uses_rt  = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
    assign load_use = idex_memread && (idex_rt != '0)
                      && ((idex_rt == rs) || ((idex_rt == rt) && uses_rt));
    assign stall    = load_use || (state_reg != ST_RUN);
    assign accept   = (state_reg == ST_RUN) && !branch_taken && !load_use && instr_valid;

    logic       dec_reg_dst;
    logic       dec_alu_src;
    logic [2:0] dec_alu_op;
    logic       dec_mem_write;
    logic       dec_mem_read;
    logic       dec_reg_write;
    logic       dec_mem_to_reg;
    logic       dec_jump;
    logic       dec_branch;
    logic       dec_jr;
    logic       dec_jal;
    logic       dec_syscall;
    logic       dec_legal;

    always_comb begin
        dec_reg_dst    = 1'b0;
        dec_alu_src    = 1'b0;
        dec_alu_op     = 3'b000;
        dec_mem_write  = 1'b0;
        dec_mem_read   = 1'b0;
        dec_reg_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_jump       = 1'b0;
        dec_branch     = 1'b0;
        dec_jr         = 1'b0;
        dec_jal        = 1'b0;
        dec_syscall    = 1'b0;
        dec_legal      = 1'b1;
        case (op)
            6'h00: begin
                dec_reg_dst   = 1'b1;
                dec_reg_write = 1'b1;
                case (funct)
                    6'h20: dec_alu_op = 3'b010;
                    6'h22: dec_alu_op = 3'b110;
                    6'h24: dec_alu_op = 3'b000;
                    6'h25: dec_alu_op = 3'b001;
                    6'h2A: dec_alu_op = 3'b111;
                    6'h08: begin
                        dec_jump      = 1'b1;
                        dec_jr        = 1'b1;
                        dec_reg_write = 1'b0;
                    end
                    6'h0C: dec_syscall = 1'b1;
                    6'h00: begin
                        dec_reg_dst   = 1'b0;
                        dec_reg_write = 1'b0;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            6'h0F: begin
                dec_alu_op    = 3'b011;
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
            end
            6'h02: dec_jump = 1'b1;
            6'h03: begin
                dec_jump      = 1'b1;
                dec_reg_write = 1'b1;
                dec_jal       = 1'b1;
            end
            6'h08, 6'h09: begin
                dec_alu_op    = 3'b010;
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
            end
            6'h0D: begin
                dec_alu_op    = 3'b001;
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
            end
            6'h04, 6'h05: begin
                dec_alu_op = 3'b110;
                dec_branch = 1'b1;
            end
            6'h23: begin
                dec_alu_op     = 3'b010;
                dec_mem_read   = 1'b1;
                dec_mem_to_reg = 1'b1;
                dec_reg_write  = 1'b1;
                dec_alu_src    = 1'b1;
            end
            6'h2B: begin
                dec_alu_op    = 3'b010;
                dec_alu_src   = 1'b1;
                dec_mem_write = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Every edge registers a bubble unless a legal instruction is accepted in RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_RUN;
            drain_cnt_reg   <= 4'd0;
            ex_ctrl_reg     <= '0;
            mem_ctrl_reg    <= 2'b00;
            wb_ctrl_reg     <= 2'b00;
            jump_reg        <= 1'b0;
            branch_reg      <= 1'b0;
            jr_reg          <= 1'b0;
            jal_reg         <= 1'b0;
            syscall_reg     <= 1'b0;
            ctrl_valid_reg  <= 1'b0;
            illegal_reg     <= 1'b0;
            syscall_req_reg <= 1'b0;
        end else begin
            ex_ctrl_reg    <= '0;
            mem_ctrl_reg   <= 2'b00;
            wb_ctrl_reg    <= 2'b00;
            jump_reg       <= 1'b0;
            branch_reg     <= 1'b0;
            jr_reg         <= 1'b0;
            jal_reg        <= 1'b0;
            syscall_reg    <= 1'b0;
            ctrl_valid_reg <= 1'b0;
            illegal_reg    <= 1'b0;
            case (state_reg)
                ST_RUN: begin
                    if (accept) begin
                        if (dec_legal) begin
                            ex_ctrl_reg    <= {dec_reg_dst, dec_alu_src, ALUOP_W'(dec_alu_op)};
                            mem_ctrl_reg   <= {dec_mem_write, dec_mem_read};
                            wb_ctrl_reg    <= {dec_reg_write, dec_mem_to_reg};
                            jump_reg       <= dec_jump;
                            branch_reg     <= dec_branch;
                            jr_reg         <= dec_jr;
                            jal_reg        <= dec_jal;
                            syscall_reg    <= dec_syscall;
                            ctrl_valid_reg <= 1'b1;
                            if (dec_syscall) begin
                                state_reg     <= ST_DRAIN;
                                drain_cnt_reg <= 4'(DRAIN_CYCLES);
                            end
                        end else begin
                            illegal_reg <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (branch_taken) begin
                        state_reg     <= ST_RUN;
                        drain_cnt_reg <= 4'd0;
                    end else if (drain_cnt_reg == 4'd0) begin
                        state_reg       <= ST_WAIT;
                        syscall_req_reg <= 1'b1;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg - 4'd1;
                    end
                end
                ST_WAIT: begin
                    if (syscall_ack) begin
                        state_reg       <= ST_RUN;
                        syscall_req_reg <= 1'b0;
                    end
                end
                default: state_reg <= ST_RUN;
            endcase
        end
    end

    assign ex_ctrl      = ex_ctrl_reg;
    assign mem_ctrl     = mem_ctrl_reg;
    assign wb_ctrl      = wb_ctrl_reg;
    assign jump         = jump_reg;
    assign branch       = branch_reg;
    assign jr_ctrl      = jr_reg;
    assign jal_ctrl     = jal_reg;
    assign syscall_ctrl = syscall_reg;
    assign ctrl_valid   = ctrl_valid_reg;
    assign illegal      = illegal_reg;
    assign syscall_req  = syscall_req_reg;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Bench for ctrl_decode_pipe: directed scenarios plus random traffic checked against a
// table-driven reference model of the decoder and syscall sequence.
module tb_ctrl_decode_pipe;

    localparam int ALUOP_W = 3;
    localparam int REG_W   = 5;
    localparam int DRAIN   = 3;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [31:0]        instr = '0;
    logic               instr_valid = 1'b0;
    logic               idex_memread = 1'b0;
    logic [REG_W-1:0]   idex_rt = '0;
    logic               branch_taken = 1'b0;
    logic               syscall_ack = 1'b0;
    logic [ALUOP_W+1:0] ex_ctrl;
    logic [1:0]         mem_ctrl;
    logic [1:0]         wb_ctrl;
    logic               jump, branch, jr_ctrl, jal_ctrl, syscall_ctrl;
    logic               ctrl_valid, stall, illegal, syscall_req;

    always #5 clk = ~clk;

    ctrl_decode_pipe #(.ALUOP_W(ALUOP_W), .REG_W(REG_W), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .idex_memread(idex_memread), .idex_rt(idex_rt), .branch_taken(branch_taken),
        .syscall_ack(syscall_ack), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
        .jump(jump), .branch(branch), .jr_ctrl(jr_ctrl), .jal_ctrl(jal_ctrl),
        .syscall_ctrl(syscall_ctrl), .ctrl_valid(ctrl_valid), .stall(stall),
        .illegal(illegal), .syscall_req(syscall_req)
    );

    int vectors = 0;
    int miscompares = 0;

    // Expected bundle layout: {ex[16:12], mem[11:10], wb[9:8], jump, branch, jr, jal, sys, valid, illegal, req}
    logic [16:0] dec_tab [int];
    int          m_mode;   // 0 run, 1 draining, 2 waiting for ack
    int          m_age;    // edges since the syscall issued
    logic        m_req;
    logic [16:0] exp_vec;

    function automatic logic [16:0] entry(input logic [4:0] ex, input logic [1:0] mem,
                                          input logic [1:0] wb, input logic [4:0] fl);
        return {ex, mem, wb, fl, 1'b1, 2'b00};
    endfunction

    function automatic logic [16:0] obs();
        return {ex_ctrl, mem_ctrl, wb_ctrl, jump, branch, jr_ctrl, jal_ctrl,
                syscall_ctrl, ctrl_valid, illegal, syscall_req};
    endfunction

    task automatic init_tab();
        dec_tab[6'h0F]    = entry(5'b01011, 2'b00, 2'b10, 5'b00000);
        dec_tab[6'h02]    = entry(5'b00000, 2'b00, 2'b00, 5'b10000);
        dec_tab[6'h03]    = entry(5'b00000, 2'b00, 2'b10, 5'b10010);
        dec_tab[6'h08]    = entry(5'b01010, 2'b00, 2'b10, 5'b00000);
        dec_tab[6'h09]    = entry(5'b01010, 2'b00, 2'b10, 5'b00000);
        dec_tab[6'h0D]    = entry(5'b01001, 2'b00, 2'b10, 5'b00000);
        dec_tab[6'h04]    = entry(5'b00110, 2'b00, 2'b00, 5'b01000);
        dec_tab[6'h05]    = entry(5'b00110, 2'b00, 2'b00, 5'b01000);
        dec_tab[6'h23]    = entry(5'b01010, 2'b01, 2'b11, 5'b00000);
        dec_tab[6'h2B]    = entry(5'b01010, 2'b10, 2'b00, 5'b00000);
        dec_tab[64+'h20]  = entry(5'b10010, 2'b00, 2'b10, 5'b00000);
        dec_tab[64+'h22]  = entry(5'b10110, 2'b00, 2'b10, 5'b00000);
        dec_tab[64+'h24]  = entry(5'b10000, 2'b00, 2'b10, 5'b00000);
        dec_tab[64+'h25]  = entry(5'b10001, 2'b00, 2'b10, 5'b00000);
        dec_tab[64+'h2A]  = entry(5'b10111, 2'b00, 2'b10, 5'b00000);
        dec_tab[64+'h08]  = entry(5'b10000, 2'b00, 2'b00, 5'b10100);
        dec_tab[64+'h0C]  = entry(5'b10000, 2'b00, 2'b10, 5'b00001);
        dec_tab[64+'h00]  = entry(5'b00000, 2'b00, 2'b00, 5'b00000);
    endtask

    function automatic bit ref_hazard();
        logic [5:0] o;
        bit rt_src;
        o = instr[31:26];
        rt_src = (o == 6'h00) || (o == 6'h04) || (o == 6'h05) || (o == 6'h2B);
        return idex_memread && (idex_rt != 0) &&
               ((idex_rt == instr[25:21]) || (rt_src && (idex_rt == instr[20:16])));
    endfunction

    function automatic logic ref_stall();
        return ref_hazard() || (m_mode != 0);
    endfunction

    function automatic int key_of(input logic [31:0] ins);
        return (ins[31:26] == 6'h00) ? 64 + int'(ins[5:0]) : int'(ins[31:26]);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_age = 0; m_req = 1'b0; exp_vec = '0;
    endtask

    task automatic model_step();
        logic [16:0] e;
        int k;
        e = '0;
        if (m_mode == 0) begin
            if (!branch_taken && !ref_hazard() && instr_valid) begin
                k = key_of(instr);
                if (dec_tab.exists(k)) begin
                    e = dec_tab[k];
                    if (e[3]) begin m_mode = 1; m_age = 0; end
                end else begin
                    e[1] = 1'b1;
                end
            end
        end else if (m_mode == 1) begin
            if (branch_taken) m_mode = 0;
            else begin
                m_age++;
                if (m_age == DRAIN + 1) begin m_mode = 2; m_req = 1'b1; end
            end
        end else begin
            if (syscall_ack) begin m_mode = 0; m_req = 1'b0; end
        end
        e[0] = m_req;
        exp_vec = e;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        $display("t=%0t instr=%h v=%0b mr=%0b rt=%0d bt=%0b ack=%0b -> out=%h stall=%0b",
                 $time, instr, instr_valid, idex_memread, idex_rt, branch_taken, syscall_ack, obs(), stall);
    endtask

    task automatic drive(input logic [31:0] i, input logic v, input logic mr,
                         input logic [4:0] r, input logic bt, input logic ack);
        instr = i; instr_valid = v; idex_memread = mr; idex_rt = REG_W'(r);
        branch_taken = bt; syscall_ack = ack;
    endtask

    task automatic test_reset();
        drive(32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        reset = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (obs() !== 17'h0) begin miscompares++; $display("FAIL reset_outputs: got %h want 0", obs()); end
        vectors++;
        if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %0b want 0", stall); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tick();
        vectors++;
        if (obs() !== exp_vec) begin miscompares++; $display("FAIL reset_idle: got %h want %h", obs(), exp_vec); end
    endtask

    task automatic test_lw();
        drive(32'h8C220004, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        vectors++;
        if ({wb_ctrl, mem_ctrl, ex_ctrl, ctrl_valid} !== {2'b11, 2'b01, 5'b01010, 1'b1}) begin
            miscompares++;
            $display("FAIL lw_bundle: got wb=%b mem=%b ex=%b v=%b want 11 01 01010 1", wb_ctrl, mem_ctrl, ex_ctrl, ctrl_valid);
        end
        vectors++;
        if (obs() !== exp_vec) begin miscompares++; $display("FAIL lw_model: got %h want %h", obs(), exp_vec); end
    endtask

    task automatic test_load_use();
        drive(32'h00441820, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0);
        #1;
        vectors++;
        if (stall !== 1'b1) begin miscompares++; $display("FAIL loaduse_stall: got %0b want 1", stall); end
        tick();
        vectors++;
        if (obs() !== 17'h0) begin miscompares++; $display("FAIL loaduse_bubble: got %h want 0", obs()); end
        idex_memread = 1'b0;
        #1;
        vectors++;
        if (stall !== 1'b0) begin miscompares++; $display("FAIL loaduse_release: got %0b want 0", stall); end
        tick();
        vectors++;
        if ({ex_ctrl, wb_ctrl, ctrl_valid} !== {5'b10010, 2'b10, 1'b1}) begin
            miscompares++;
            $display("FAIL loaduse_add: got ex=%b wb=%b v=%b want 10010 10 1", ex_ctrl, wb_ctrl, ctrl_valid);
        end
    endtask

    task automatic test_branch_stall();
        // illegal opcode with rs matching the load: flush must win, so no illegal pulse
        drive(32'hFC440000, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0);
        #1;
        vectors++;
        if (stall !== ref_stall()) begin miscompares++; $display("FAIL flush_stall: got %0b want %0b", stall, ref_stall()); end
        tick();
        vectors++;
        if (obs() !== 17'h0) begin miscompares++; $display("FAIL flush_bubble: got %h want 0", obs()); end
        drive(32'h00000000, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        vectors++;
        if ({ex_ctrl, wb_ctrl, ctrl_valid} !== {5'b00000, 2'b00, 1'b1}) begin
            miscompares++;
            $display("FAIL nop_bundle: got %h want valid-only", obs());
        end
    endtask

    task automatic test_illegal();
        drive(32'hFC000000, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        vectors++;
        if ({illegal, ctrl_valid, ex_ctrl, wb_ctrl} !== {1'b1, 1'b0, 5'b0, 2'b0}) begin
            miscompares++;
            $display("FAIL illegal_pulse: got ill=%0b v=%0b out=%h want 1 0", illegal, ctrl_valid, obs());
        end
        drive(32'hFC000000, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        vectors++;
        if (illegal !== 1'b0) begin miscompares++; $display("FAIL illegal_width: got %0b want 0", illegal); end
    endtask

    task automatic test_syscall();
        drive(32'h0000000C, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        vectors++;
        if ({syscall_ctrl, ctrl_valid, stall} !== 3'b111) begin
            miscompares++;
            $display("FAIL sys_issue: got sys=%0b v=%0b stall=%0b want 111", syscall_ctrl, ctrl_valid, stall);
        end
        drive(32'h0000000C, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < DRAIN; i++) begin
            tick();
            vectors++;
            if ({syscall_req, ctrl_valid, syscall_ctrl, stall} !== 4'b0001) begin
                miscompares++;
                $display("FAIL sys_drain%0d: got req=%0b v=%0b sys=%0b stall=%0b want 0001", i, syscall_req, ctrl_valid, syscall_ctrl, stall);
            end
        end
        tick();
        vectors++;
        if ({syscall_req, stall} !== 2'b11) begin
            miscompares++;
            $display("FAIL sys_req_rise: got req=%0b stall=%0b want 11", syscall_req, stall);
        end
        branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0;
        vectors++;
        if ({syscall_req, ctrl_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL sys_wait_branch: got req=%0b v=%0b want 10", syscall_req, ctrl_valid);
        end
        syscall_ack = 1'b1;
        tick();
        syscall_ack = 1'b0;
        vectors++;
        if ({syscall_req, stall} !== 2'b00) begin
            miscompares++;
            $display("FAIL sys_ack: got req=%0b stall=%0b want 00", syscall_req, stall);
        end
        vectors++;
        if (obs() !== exp_vec) begin miscompares++; $display("FAIL sys_model: got %h want %h", obs(), exp_vec); end
    endtask

    task automatic test_syscall_cancel();
        int seen;
        drive(32'h0000000C, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        instr_valid = 1'b0;
        tick();
        branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0;
        seen = 0;
        for (int i = 0; i < DRAIN + 4; i++) begin
            tick();
            if (syscall_req !== 1'b0) seen++;
        end
        vectors++;
        if (seen != 0) begin miscompares++; $display("FAIL cancel_req: got %0d req cycles want 0", seen); end
        vectors++;
        if (stall !== 1'b0) begin miscompares++; $display("FAIL cancel_stall: got %0b want 0", stall); end
    endtask

    task automatic test_reset_in_wait();
        int budget;
        drive(32'h0000000C, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        instr_valid = 1'b0;
        budget = 0;
        while (syscall_req !== 1'b1 && budget < 12) begin
            tick();
            budget++;
        end
        vectors++;
        if (syscall_req !== 1'b1) begin miscompares++; $display("FAIL wait_reach: got req=%0b want 1 within 12 cycles", syscall_req); end
        #2 reset = 1'b1;
        model_reset();
        #1;
        vectors++;
        if ({obs(), stall} !== 18'h0) begin miscompares++; $display("FAIL async_reset: got %h stall=%0b want 0", obs(), stall); end
        @(posedge clk);
        #1 reset = 1'b0;
        drive(32'h00441820, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        vectors++;
        if ({ex_ctrl, wb_ctrl, ctrl_valid} !== {5'b10010, 2'b10, 1'b1}) begin
            miscompares++;
            $display("FAIL post_reset_add: got ex=%b wb=%b v=%b want 10010 10 1", ex_ctrl, wb_ctrl, ctrl_valid);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [5:0]  o, f;
        int k;
        w = $urandom;
        w[25:21] = 5'($urandom_range(0, 7));
        w[20:16] = 5'($urandom_range(0, 7));
        k = $urandom_range(0, 21);
        o = 6'h00;
        f = w[5:0];
        case (k)
            0: f = 6'h20;  1: f = 6'h22;  2: f = 6'h24;  3: f = 6'h25;
            4: f = 6'h2A;  5: f = 6'h08;  6: f = 6'h00;  7: f = 6'h01;
            8: o = 6'h0F;  9: o = 6'h02;  10: o = 6'h03; 11: o = 6'h08;
            12: o = 6'h09; 13: o = 6'h0D; 14: o = 6'h04; 15: o = 6'h05;
            16: o = 6'h23; 17: o = 6'h2B; 18: o = w[31:26];
            19: o = 6'h00;
            default: f = 6'h0C;
        endcase
        w[31:26] = o;
        if (o == 6'h00) w[5:0] = f;
        return w;
    endfunction

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            drive(rand_instr(), ($urandom_range(0, 9) != 0), ($urandom_range(0, 2) == 0),
                  5'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0));
            #1;
            vectors++;
            if (stall !== ref_stall()) begin
                miscompares++;
                $display("FAIL rand_stall[%0d]: got %0b want %0b", n, stall, ref_stall());
            end
            tick();
            vectors++;
            if (obs() !== exp_vec) begin
                miscompares++;
                $display("FAIL rand_out[%0d]: got %h want %h", n, obs(), exp_vec);
            end
        end
    endtask

    initial begin
        init_tab();
        model_reset();
        test_reset();
        test_lw();
        test_load_use();
        test_branch_stall();
        test_illegal();
        test_syscall();
        test_syscall_cancel();
        test_reset_in_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ctrl_decode_pipe.md
Name: ctrl_decode_pipe

Overview:
Registered, parametrised successor to the combinational MIPS control decoder. Sits at the ID/EX boundary and decodes one instruction per cycle into EX/MEM/WB control bundles. Adds load-use hazard stalling, branch-flush bubble insertion, illegal-opcode flagging and a syscall drain/handshake FSM. All outputs are registered, so latency is 1 cycle.

Parameters:
ALUOP_W, 3, ALU opcode width (>=3); codes zero-extended to this width
REG_W, 5, register specifier width used for hazard compare
DRAIN_CYCLES, 3, cycles waited after a SYSCALL issues before syscall_req is raised (1..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
instr  in  32  instruction in ID
instr_valid  in  1  instr is meaningful this cycle
idex_memread  in  1  instruction currently in EX is a load
idex_rt  in  REG_W  destination of that load
branch_taken  in  1  branch/jump resolved taken this cycle
syscall_ack  in  1  syscall service complete
ex_ctrl  out  ALUOP_W+2  {RegDst, ALUsrc, ALUop}
mem_ctrl  out  2  {MemWrite, MemRead}
wb_ctrl  out  2  {RegWrite, MemToReg}
jump, branch, jr_ctrl, jal_ctrl, syscall_ctrl  out  1 each  per-instruction flags
ctrl_valid  out  1  registered bundle is a real instruction
stall  out  1  hold PC and IF/ID (combinational)
illegal  out  1  one-cycle pulse, unrecognised opcode/funct
syscall_req  out  1  level; request syscall service

Behaviour:
- Reset (async): all outputs 0, FSM=RUN, drain counter 0.
- Decode table (op hex / funct hex) -> ALUop: LUI 0F ->011 (RegWrite, ALUsrc); J 02 -> Jump; JAL 03 -> Jump, RegWrite, jal; ADDI 08 / ADDIU 09 ->010 (RegWrite, ALUsrc); ORI 0D ->001 (RegWrite, ALUsrc); BEQ 04 / BNE 05 ->110 (Branch); LW 23 ->010 (MemRead, MemToReg, RegWrite, ALUsrc); SW 2B ->010 (ALUsrc, MemWrite). SPECIAL 00 sets RegDst and RegWrite, then: ADD 20 ->010, SUB 22 ->110, AND 24 ->000, OR 25 ->001, SLT 2A ->111, JR 08 -> Jump, jr, RegWrite=0; SYSCALL 0C -> syscall_ctrl, RegWrite; funct 00 = NOP -> all-zero bundle, ctrl_valid=1.
- Any other op/funct: bundle zeroed, ctrl_valid=0, illegal=1 for 1 cycle. No simulation print.
- Bubble = all control outputs 0, ctrl_valid=0.
- Load-use hazard (combinational stall): idex_memread & idex_rt!=0 & (idex_rt==rs | (idex_rt==rt & op in {SPECIAL,BEQ,BNE,SW})). Next edge registers a bubble; instr must be held by upstream.
- Priority at each edge: reset > branch_taken (bubble, stall ignored) > stall > decode. instr_valid=0 -> bubble.
- FSM RUN: a valid SYSCALL decoded without flush issues its bundle, loads counter with DRAIN_CYCLES and moves to DRAIN. DRAIN: stall=1, bubbles issued, counter decrements; at 0 -> WAIT. branch_taken in DRAIN cancels: -> RUN, no syscall_req. WAIT: stall=1, syscall_req=1, bubbles; branch_taken ignored; syscall_ack -> RUN and syscall_req drops the same edge. syscall_ack outside WAIT is ignored.
- A SYSCALL arriving while stalled is not accepted until the stall clears.

Test Plan:
- Reset mid-WAIT: assert reset with syscall_req=1 -> all outputs 0 immediately, FSM RUN, next ADD decodes normally.
- instr=0x8C220004 (LW) -> next cycle wb_ctrl=2'b11, mem_ctrl=2'b01, ex_ctrl=5'b01010, ctrl_valid=1.
- Load-use: idex_memread=1, idex_rt=2, instr ADD $3,$2,$4 (0x00441820) -> stall=1, bubble registered; dropping idex_memread -> ex_ctrl=5'b10010, wb_ctrl=2'b10.
- Stall plus branch_taken in the same cycle -> bubble, stall ignored, no illegal.
- Illegal op 0x3F -> illegal pulses 1 cycle, ctrl_valid=0.
- SYSCALL (0x0000000C) with DRAIN_CYCLES=3 -> syscall_ctrl=1 for 1 cycle, 3 bubble cycles, then syscall_req=1 until ack, then RUN. Repeat with branch_taken during DRAIN -> syscall_req never asserts.
